// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 slave between several masters.
// Tenures are bounded by the owner's CYC; outstanding transfers are counted to route ACK/ERR.
module wb_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat,
  output logic [NUM_MASTERS-1:0]        m_stall,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DW-1:0]                 m_dat_s,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [AW-1:0]                 s_adr,
  output logic [DW/8-1:0]               s_sel,
  output logic [DW-1:0]                 s_dat_m,
  input  logic                          s_stall,
  input  logic                          s_ack,
  input  logic                          s_err,
  input  logic [DW-1:0]                 s_dat_s,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          proto_err
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] OUT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [IW-1:0]          last, last_nxt;
  logic [CW-1:0]          outst, outst_nxt;
  logic                   proto_err_nxt;

  logic [IW-1:0]          g;
  logic [IW-1:0]          arb_idx;
  logic [IW-1:0]          win;
  logic                   found;
  logic                   at_max;
  logic                   has_outst;
  logic                   resp;
  logic                   inc;
  logic                   dec;

  assign m_dat_s = s_dat_s;

  // Index of the current owner, decoded from the one-hot grant register.
  always_comb begin
    g = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (grant[i]) g = IW'(i);
    end
  end

  // State, ownership and transfer-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= IW'(NUM_MASTERS - 1);
      outst     <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      outst     <= outst_nxt;
      proto_err <= proto_err_nxt;
    end
  end

  // Next-state logic plus combinational bus muxing from the owner.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_nxt      = last;
    outst_nxt     = outst;
    proto_err_nxt = 1'b0;
    arb_idx       = '0;
    win           = '0;
    found         = 1'b0;
    at_max        = 1'b0;
    has_outst     = 1'b0;
    resp          = 1'b0;
    inc           = 1'b0;
    dec           = 1'b0;
    s_cyc         = 1'b0;
    s_stb         = 1'b0;
    s_we          = 1'b0;
    s_adr         = '0;
    s_sel         = '0;
    s_dat_m       = '0;
    m_stall       = '1;
    m_ack         = '0;
    m_err         = '0;

    case (state)
      IDLE: begin
        outst_nxt = '0;
        // Search starts just after the previous winner so ownership rotates.
        for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
          arb_idx = IW'((int'(last) + i) % int'(NUM_MASTERS));
          if (!found && m_cyc[arb_idx]) begin
            found = 1'b1;
            win   = arb_idx;
          end
        end
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = NUM_MASTERS'(1) << win;
          last_nxt  = win;
        end
      end

      BUSY: begin
        at_max    = (outst == OUT_MAX);
        has_outst = (outst != '0);
        resp      = s_ack | s_err;

        s_cyc   = m_cyc[g];
        s_stb   = m_cyc[g] & m_stb[g] & ~at_max;
        s_we    = m_we[g];
        s_adr   = m_adr[g*AW +: AW];
        s_sel   = m_sel[g*SW +: SW];
        s_dat_m = m_dat[g*DW +: DW];

        m_stall[g] = s_stall | at_max;
        m_ack[g]   = s_cyc & s_ack & has_outst;
        m_err[g]   = s_cyc & s_err & has_outst;

        inc = s_cyc & s_stb & ~s_stall;
        dec = s_cyc & resp & has_outst;
        if (inc && !dec)      outst_nxt = outst + CW'(1);
        else if (dec && !inc) outst_nxt = outst - CW'(1);

        proto_err_nxt = s_cyc & resp & ~has_outst;

        // Owner dropped CYC: tenure ends, counter and grant clear next cycle.
        if (!m_cyc[g]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          outst_nxt = '0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: two instances (deep and shallow outstanding limit) share stimulus
// and are checked every cycle against a cycle-level ownership/count model.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr;
  logic [7:0]  m_sel;
  logic [63:0] m_dat;
  logic        s_stall, s_ack, s_err;
  logic [31:0] s_dat_s;

  logic [1:0]  o_stall [2];
  logic [1:0]  o_ack   [2];
  logic [1:0]  o_err   [2];
  logic [1:0]  o_grant [2];
  logic [31:0] o_dat_s [2];
  logic [31:0] o_adr   [2];
  logic [31:0] o_dat_m [2];
  logic [3:0]  o_sel   [2];
  logic        o_cyc   [2];
  logic        o_stb   [2];
  logic        o_we    [2];
  logic        o_perr  [2];

  int n_chk  = 0;
  int n_pass = 0;
  int acks0  = 0;

  wb_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .MAX_OUTSTANDING(16)) dut0 (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_sel(m_sel), .m_dat(m_dat), .m_stall(o_stall[0]), .m_ack(o_ack[0]), .m_err(o_err[0]),
    .m_dat_s(o_dat_s[0]), .s_cyc(o_cyc[0]), .s_stb(o_stb[0]), .s_we(o_we[0]),
    .s_adr(o_adr[0]), .s_sel(o_sel[0]), .s_dat_m(o_dat_m[0]), .s_stall(s_stall),
    .s_ack(s_ack), .s_err(s_err), .s_dat_s(s_dat_s), .grant(o_grant[0]),
    .proto_err(o_perr[0]));

  wb_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .MAX_OUTSTANDING(2)) dut1 (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_sel(m_sel), .m_dat(m_dat), .m_stall(o_stall[1]), .m_ack(o_ack[1]), .m_err(o_err[1]),
    .m_dat_s(o_dat_s[1]), .s_cyc(o_cyc[1]), .s_stb(o_stb[1]), .s_we(o_we[1]),
    .s_adr(o_adr[1]), .s_sel(o_sel[1]), .s_dat_m(o_dat_m[1]), .s_stall(s_stall),
    .s_ack(s_ack), .s_err(s_err), .s_dat_s(s_dat_s), .grant(o_grant[1]),
    .proto_err(o_perr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
  endtask

  // Reference model: owner (-1 = none), last winner, transfer count, pending proto_err.
  int maxo [2] = '{16, 2};
  int own [2], lst [2], cnt [2];
  bit perr [2];
  int own_n [2], lst_n [2], cnt_n [2];
  bit perr_n [2];

  int         g, w;
  bit         full, e_cyc, e_stb;
  logic [1:0] e_stall, e_ack, e_err, e_grant;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        own[k] = -1; lst[k] = 1; cnt[k] = 0; perr[k] = 0;
        own_n[k] = -1; lst_n[k] = 1; cnt_n[k] = 0; perr_n[k] = 0;
      end else begin
        own[k] = own_n[k]; lst[k] = lst_n[k]; cnt[k] = cnt_n[k]; perr[k] = perr_n[k];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        g = own[k];
        e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00; e_grant = 2'b00;
        e_cyc = 0; e_stb = 0; full = 0;
        if (g >= 0) begin
          full       = (cnt[k] == maxo[k]);
          e_grant[g] = 1'b1;
          e_cyc      = m_cyc[g];
          e_stb      = e_cyc && m_stb[g] && !full;
          e_stall[g] = s_stall || full;
          e_ack[g]   = e_cyc && s_ack && cnt[k] > 0;
          e_err[g]   = e_cyc && s_err && cnt[k] > 0;
        end
        check("grant", k, 64'(o_grant[k]), 64'(e_grant));
        check("s_cyc", k, 64'(o_cyc[k]), 64'(e_cyc));
        check("s_stb", k, 64'(o_stb[k]), 64'(e_stb));
        check("m_stall", k, 64'(o_stall[k]), 64'(e_stall));
        check("m_ack", k, 64'(o_ack[k]), 64'(e_ack));
        check("m_err", k, 64'(o_err[k]), 64'(e_err));
        check("proto_err", k, 64'(o_perr[k]), 64'(perr[k]));
        check("m_dat_s", k, 64'(o_dat_s[k]), 64'(s_dat_s));
        if (e_cyc) begin
          check("s_we", k, 64'(o_we[k]), 64'(m_we[g]));
          check("s_adr", k, 64'(o_adr[k]), 64'(m_adr[g*32 +: 32]));
          check("s_sel", k, 64'(o_sel[k]), 64'(m_sel[g*4 +: 4]));
          check("s_dat_m", k, 64'(o_dat_m[k]), 64'(m_dat[g*32 +: 32]));
        end
        // Next model state.
        own_n[k] = g; lst_n[k] = lst[k]; cnt_n[k] = cnt[k]; perr_n[k] = 0;
        if (g < 0) begin
          cnt_n[k] = 0;
          for (int i = 1; i <= 2; i++) begin
            w = (lst[k] + i) % 2;
            if (own_n[k] < 0 && m_cyc[w]) begin
              own_n[k] = w; lst_n[k] = w;
            end
          end
        end else if (!m_cyc[g]) begin
          own_n[k] = -1; cnt_n[k] = 0;
        end else begin
          cnt_n[k] = cnt[k] + ((e_stb && !s_stall) ? 1 : 0)
                            - (((s_ack || s_err) && cnt[k] > 0) ? 1 : 0);
          perr_n[k] = (s_ack || s_err) && cnt[k] == 0;
        end
      end
    end
  end

  always @(negedge clk) if (!rst && o_ack[0][0]) acks0++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(int i, logic cyc, logic stb, logic we, logic [31:0] adr,
                       logic [3:0] sel, logic [31:0] dat);
    m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
    m_adr[i*32 +: 32] = adr; m_sel[i*4 +: 4] = sel; m_dat[i*32 +: 32] = dat;
  endtask

  task automatic set_s(logic stall, logic ack, logic err, logic [31:0] dat);
    s_stall = stall; s_ack = ack; s_err = err; s_dat_s = dat;
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    set_s(0, 0, 0, 0);
  endtask

  int a0;

  initial begin
    rst = 1'b1;
    idle_all();
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single master: four pipelined reads, ACK two cycles after acceptance.
    a0 = acks0;
    set_m(0, 1, 1, 0, 32'h10, 4'hF, 0);
    @(negedge clk);
    check("lit_c0_s_cyc", 0, 64'(o_cyc[0]), 64'd0);
    check("lit_c0_grant", 0, 64'(o_grant[0]), 64'd0);
    tick();
    @(negedge clk);
    check("lit_c1_s_cyc", 0, 64'(o_cyc[0]), 64'd1);
    check("lit_c1_grant", 0, 64'(o_grant[0]), 64'd1);
    tick();
    set_m(0, 1, 1, 0, 32'h14, 4'hF, 0); tick();
    set_m(0, 1, 1, 0, 32'h18, 4'hF, 0); set_s(0, 1, 0, 32'hCAFE0001); tick();
    set_m(0, 1, 1, 0, 32'h1C, 4'hF, 0); set_s(0, 1, 0, 32'hCAFE0002); tick();
    set_m(0, 1, 0, 0, 32'h1C, 4'hF, 0); set_s(0, 1, 0, 32'hCAFE0003); tick();
    set_s(0, 1, 0, 32'hCAFE0004); tick();
    set_m(0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    @(negedge clk);
    check("lit_release_s_cyc", 0, 64'(o_cyc[0]), 64'd0);
    tick(); tick();
    check("lit_ack_count", 0, 64'(acks0 - a0), 64'd4);

    // Contention from reset: m0 first, then m1, then m0 again.
    rst = 1'b1; tick(); rst = 1'b0;
    set_m(0, 1, 0, 0, 32'hA0, 4'h1, 0);
    set_m(1, 1, 0, 0, 32'hB0, 4'h2, 0);
    tick();
    @(negedge clk);
    check("lit_cont_first", 0, 64'(o_grant[0]), 64'd1);
    tick(); tick();
    set_m(0, 0, 0, 0, 0, 0, 0); tick();
    @(negedge clk);
    check("lit_cont_gap_cyc", 0, 64'(o_cyc[0]), 64'd0);
    check("lit_cont_gap_grant", 0, 64'(o_grant[0]), 64'd0);
    tick();
    @(negedge clk);
    check("lit_cont_second", 0, 64'(o_grant[0]), 64'd2);
    tick();
    set_m(1, 0, 0, 0, 0, 0, 0); tick(); tick();
    set_m(0, 1, 0, 0, 32'hA4, 4'h1, 0);
    set_m(1, 1, 0, 0, 32'hB4, 4'h2, 0);
    tick();
    @(negedge clk);
    check("lit_cont_rr", 0, 64'(o_grant[0]), 64'd1);
    tick();
    idle_all(); tick(); tick();

    // Stall passthrough on an m1 write.
    set_m(1, 1, 1, 1, 32'h100, 4'hF, 32'hDEADBEEF); tick();
    set_s(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lit_stall_m1", 0, 64'(o_stall[0][1]), 64'd1);
      check("lit_stall_m0", 0, 64'(o_stall[0][0]), 64'd1);
      check("lit_stall_adr", 0, 64'(o_adr[0]), 64'h100);
      check("lit_stall_dat", 0, 64'(o_dat_m[0]), 64'hDEADBEEF);
      tick();
    end
    set_s(0, 0, 0, 0);
    @(negedge clk);
    check("lit_stall_release", 0, 64'(o_stall[0][1]), 64'd0);
    check("lit_stall_stb", 0, 64'(o_stb[0]), 64'd1);
    tick();
    set_m(1, 1, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF); set_s(0, 1, 0, 0);
    @(negedge clk);
    check("lit_write_ack", 0, 64'(o_ack[0]), 64'd2);
    tick();
    idle_all(); tick(); tick();

    // Outstanding limit on the shallow instance.
    set_m(0, 1, 1, 0, 32'h200, 4'hF, 0); tick();
    tick();
    set_m(0, 1, 1, 0, 32'h204, 4'hF, 0); tick();
    set_m(0, 1, 1, 0, 32'h208, 4'hF, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("lit_lim_stall", 1, 64'(o_stall[1][0]), 64'd1);
      check("lit_lim_stb", 1, 64'(o_stb[1]), 64'd0);
      tick();
    end
    set_s(0, 1, 0, 0);
    @(negedge clk);
    check("lit_lim_ack", 1, 64'(o_ack[1]), 64'd1);
    check("lit_lim_ack_stb", 1, 64'(o_stb[1]), 64'd0);
    tick();
    set_s(0, 0, 0, 0);
    @(negedge clk);
    check("lit_lim_accept_stb", 1, 64'(o_stb[1]), 64'd1);
    check("lit_lim_accept_stall", 1, 64'(o_stall[1][0]), 64'd0);
    tick();
    set_m(0, 1, 0, 0, 32'h208, 4'hF, 0); tick();
    set_s(0, 1, 0, 0); tick(); tick();
    idle_all(); tick(); tick();

    // Spurious ACK, ERR forwarding, late ACK after release.
    set_m(0, 1, 0, 0, 32'h300, 4'hF, 0); tick();
    set_s(0, 1, 0, 0);
    @(negedge clk);
    check("lit_spur_ack", 0, 64'(o_ack[0]), 64'd0);
    tick();
    set_s(0, 0, 0, 0); set_m(0, 1, 1, 0, 32'h304, 4'hF, 0);
    @(negedge clk);
    check("lit_spur_perr", 0, 64'(o_perr[0]), 64'd1);
    tick();
    set_m(0, 1, 0, 0, 32'h304, 4'hF, 0); set_s(0, 0, 1, 0);
    @(negedge clk);
    check("lit_perr_clear", 0, 64'(o_perr[0]), 64'd0);
    check("lit_err_fwd", 0, 64'(o_err[0]), 64'd1);
    tick();
    set_m(0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0); tick();
    set_s(0, 1, 0, 0);
    @(negedge clk);
    check("lit_late_ack", 0, 64'(o_ack[0]), 64'd0);
    tick();
    set_s(0, 0, 0, 0);
    @(negedge clk);
    check("lit_late_perr", 0, 64'(o_perr[0]), 64'd0);
    tick();

    // Async reset mid-tenure with three transfers outstanding.
    set_m(1, 1, 1, 0, 32'h400, 4'hF, 0); tick();
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("lit_arst_cyc", k, 64'(o_cyc[k]), 64'd0);
      check("lit_arst_grant", k, 64'(o_grant[k]), 64'd0);
      check("lit_arst_stall", k, 64'(o_stall[k]), 64'd3);
    end
    set_m(0, 1, 0, 0, 32'h500, 4'hF, 0);
    set_m(1, 1, 0, 0, 32'h600, 4'hF, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("lit_arst_winner", 0, 64'(o_grant[0]), 64'd1);
    tick();
    idle_all(); tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Round-robin arbiter that shares one classic pipelined Wishbone B4 slave port between NUM_MASTERS master ports, for example the Ibex instruction and data buses onto a shared RAM/peripheral bus. Each tenure is bounded by the granted master's CYC. The block tracks outstanding STB transfers so ACK/ERR are routed only to the owning master and the outstanding depth stays limited. Its slave-side output is intended to pass the bus protocol checker unmodified.

Parameters:
NUM_MASTERS, 2, number of requesting master ports (2..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
MAX_OUTSTANDING, 16, maximum accepted-but-unacknowledged transfers per tenure (1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m_cyc  in  NUM_MASTERS  per-master CYC
m_stb  in  NUM_MASTERS  per-master STB
m_we  in  NUM_MASTERS  per-master WE
m_adr  in  NUM_MASTERS*AW  packed addresses; master i at [i*AW +: AW]
m_sel  in  NUM_MASTERS*DW/8  packed byte selects
m_dat  in  NUM_MASTERS*DW  packed master write data
m_stall  out  NUM_MASTERS  per-master STALL
m_ack  out  NUM_MASTERS  per-master ACK
m_err  out  NUM_MASTERS  per-master ERR
m_dat_s  out  DW  read data, broadcast to all masters (s_dat_s passthrough)
s_cyc  out  1  slave CYC
s_stb  out  1  slave STB
s_we  out  1  slave WE
s_adr  out  AW  slave address
s_sel  out  DW/8  slave byte selects
s_dat_m  out  DW  slave write data
s_stall  in  1  slave STALL
s_ack  in  1  slave ACK
s_err  in  1  slave ERR
s_dat_s  in  DW  slave read data
grant  out  NUM_MASTERS  one-hot current owner; 0 when idle
proto_err  out  1  one-cycle pulse on an ACK/ERR received with no outstanding transfer

Behaviour:
- FSM: IDLE, BUSY. The state, grant, last-grant pointer `last`, outstanding counter `outst` and proto_err are registers. All master/slave muxing is combinational from `grant`.
- Reset (async, rst=1):
  - state=IDLE, grant=0, last=NUM_MASTERS-1 (master 0 wins first), outst=0, proto_err=0.
  - Outputs: s_cyc=s_stb=0, m_ack=m_err=0, m_stall=all 1.
  - Reset mid-tenure aborts the tenure immediately; no ACK/ERR is forwarded.
- IDLE:
  - s_cyc=0; all m_stall=1.
  - If any m_cyc=1, pick the first requester searching from (last+1) mod NUM_MASTERS upward with wrap.
  - Register grant=onehot(winner) and last=winner, then go to BUSY.
  - Arbitration latency: exactly one cycle from request to s_cyc.
- BUSY, with g = granted index:
  - s_cyc = m_cyc[g].
  - s_we, s_adr, s_sel and s_dat_m come from master g.
  - s_stb = m_cyc[g] & m_stb[g] & (outst != MAX_OUTSTANDING).
  - m_stall[g] = s_stall | (outst == MAX_OUTSTANDING); m_stall of every other master = 1.
  - m_ack[g] = s_ack & (outst != 0); m_err[g] likewise from s_err; the other masters get 0.
- Counter: increment on s_cyc & s_stb & !s_stall; decrement on (s_ack|s_err) & outst!=0. Both in the same cycle leave it unchanged. It never exceeds MAX_OUTSTANDING and never goes below 0.
- proto_err = 1 for one cycle after any cycle with s_cyc & (s_ack|s_err) & outst==0. That ACK/ERR is dropped and not forwarded.
- Release: when m_cyc[g]=0 in BUSY, s_cyc drops in the same cycle (combinational). Next cycle: state=IDLE, grant=0, outst=0.
  - Late ACK/ERR arriving after release is ignored: no forwarding, no proto_err.
  - Minimum one-cycle s_cyc=0 gap between tenures.
- No preemption: a master holding m_cyc keeps the grant indefinitely. Fairness applies only at tenure boundaries.
- Requests while BUSY from non-granted masters are stalled (m_stall=1) and never see ACK/ERR.
- Error handling: ERR is treated like ACK for counting. The tenure continues until the master drops CYC.

Test Plan:
- Single master: m0 issues 4 back-to-back reads, slave ACKs each 2 cycles later -> s_cyc rises 1 cycle after m_cyc[0]; 4 m_ack[0] pulses; outst returns to 0; grant=01 throughout.
- Contention: m0 and m1 raise CYC in the same cycle from reset -> grant=01 first. After m0 drops CYC, one idle cycle, then grant=10. A following simultaneous request -> grant=01 (round robin).
- Stall passthrough: slave holds s_stall=1 for 3 cycles during m1 write adr=0x100, dat=0xDEADBEEF, sel=0xF -> m_stall[1]=1 for those 3 cycles; s_adr/s_dat_m stable; m_stall[0]=1 throughout.
- Outstanding limit, MAX_OUTSTANDING=2: master issues 3 STBs while the slave withholds ACK -> third STB sees m_stall=1 and s_stb=0 until the first ACK, then is accepted the same cycle outst drops to 1.
- Spurious/late ACK: s_ack with outst=0 during BUSY -> proto_err pulses 1 cycle, m_ack=0. ACK after CYC drop -> nothing forwarded, proto_err stays 0.
- Async reset mid-tenure with outst=3 -> s_cyc=0 and grant=0 immediately, without waiting for a clock edge. After release, m0 wins the first arbitration.
